// File: rtl/btn_debounce.sv
// Per-channel push-button debouncer: 2-flop synchroniser, stability counter, press/release strobes.
// Define BTN_DEBOUNCE_HOLD_EN to build the long-press (o_hold_stb) counters.
module btn_debounce #(
  parameter int unsigned WIDTH           = 6,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter bit          ACTIVE_LOW      = 1'b0,
  parameter int unsigned HOLD_CYCLES     = 1024
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_btn,
  output logic [WIDTH-1:0] o_state,
  output logic [WIDTH-1:0] o_press_stb,
  output logic [WIDTH-1:0] o_release_stb,
  output logic [WIDTH-1:0] o_hold_stb
);

  localparam int unsigned      CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES == 0 || HOLD_CYCLES == 0) begin : g_param_check
    $error("btn_debounce: DEBOUNCE_CYCLES and HOLD_CYCLES must be >= 1");
  end

  logic [WIDTH-1:0]            w_raw;
  logic [WIDTH-1:0]            r_sync1;
  logic [WIDTH-1:0]            r_sync2;
  logic [WIDTH-1:0]            r_state;
  logic [WIDTH-1:0]            r_press;
  logic [WIDTH-1:0]            r_release;
  logic [WIDTH-1:0][CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0][CNT_W-1:0] w_cnt_nxt;
  logic [WIDTH-1:0]            w_state_nxt;
  logic [WIDTH-1:0]            w_press_nxt;
  logic [WIDTH-1:0]            w_release_nxt;

  assign w_raw = ACTIVE_LOW ? ~i_btn : i_btn;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
    end
  end

  // Any cycle where the synchronised level agrees with the state restarts qualification.
  always_comb begin
    w_cnt_nxt     = r_cnt;
    w_state_nxt   = r_state;
    w_press_nxt   = '0;
    w_release_nxt = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (r_sync2[i] == r_state[i]) begin
        w_cnt_nxt[i] = '0;
      end else if (r_cnt[i] == CNT_TERM) begin
        w_cnt_nxt[i]     = '0;
        w_state_nxt[i]   = r_sync2[i];
        w_press_nxt[i]   = r_sync2[i];
        w_release_nxt[i] = ~r_sync2[i];
      end else begin
        w_cnt_nxt[i] = r_cnt[i] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt     <= '0;
      r_state   <= '0;
      r_press   <= '0;
      r_release <= '0;
    end else begin
      r_cnt     <= w_cnt_nxt;
      r_state   <= w_state_nxt;
      r_press   <= w_press_nxt;
      r_release <= w_release_nxt;
    end
  end

  assign o_state       = r_state;
  assign o_press_stb   = r_press;
  assign o_release_stb = r_release;

`ifdef BTN_DEBOUNCE_HOLD_EN
  localparam int unsigned       HOLD_W    = $clog2(HOLD_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_TERM = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_STOP = HOLD_W'(HOLD_CYCLES);

  logic [WIDTH-1:0][HOLD_W-1:0] r_hold;
  logic [WIDTH-1:0][HOLD_W-1:0] w_hold_nxt;
  logic [WIDTH-1:0]             r_hold_stb;
  logic [WIDTH-1:0]             w_hold_stb_nxt;

  // Parking at HOLD_STOP suppresses repeats until the button is released.
  always_comb begin
    w_hold_nxt     = r_hold;
    w_hold_stb_nxt = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (!r_state[i]) begin
        w_hold_nxt[i] = '0;
      end else if (r_hold[i] == HOLD_TERM) begin
        w_hold_nxt[i]     = HOLD_STOP;
        w_hold_stb_nxt[i] = 1'b1;
      end else if (r_hold[i] != HOLD_STOP) begin
        w_hold_nxt[i] = r_hold[i] + HOLD_W'(1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_hold     <= '0;
      r_hold_stb <= '0;
    end else begin
      r_hold     <= w_hold_nxt;
      r_hold_stb <= w_hold_stb_nxt;
    end
  end

  assign o_hold_stb = r_hold_stb;
`else
  assign o_hold_stb = '0;
`endif

endmodule

// File: tb/tb_btn_debounce.sv
// Self-checking bench for btn_debounce: one active-high and one active-low instance
// compared every cycle against a sliding-window reference model, plus directed timing checks.
module tb_btn_debounce;

  localparam int unsigned W = 2;
  localparam int unsigned D = 4;
  localparam int unsigned H = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n0, rst_n1;
  logic [W-1:0] btn0, btn1;
  logic [W-1:0] st0, pr0, rl0, ho0;
  logic [W-1:0] st1, pr1, rl1, ho1;
  int checks = 0;
  int errors = 0;

  btn_debounce #(
    .WIDTH(W), .DEBOUNCE_CYCLES(D), .ACTIVE_LOW(1'b0), .HOLD_CYCLES(H)
  ) u_dut_hi (
    .i_clk(clk), .i_rst_n(rst_n0), .i_btn(btn0),
    .o_state(st0), .o_press_stb(pr0), .o_release_stb(rl0), .o_hold_stb(ho0)
  );

  btn_debounce #(
    .WIDTH(W), .DEBOUNCE_CYCLES(D), .ACTIVE_LOW(1'b1), .HOLD_CYCLES(H)
  ) u_dut_lo (
    .i_clk(clk), .i_rst_n(rst_n1), .i_btn(btn1),
    .o_state(st1), .o_press_stb(pr1), .o_release_stb(rl1), .o_hold_stb(ho1)
  );

  // Reference: the state flips once the last D synchronised samples all disagree with it;
  // the synchronised sample is simply the pressed level two edges earlier (0 just after reset).
  for (genvar k = 0; k < 2; k++) begin : g_model
    logic [W-1:0] e_state   = '0;
    logic [W-1:0] e_press   = '0;
    logic [W-1:0] e_release = '0;
    logic [W-1:0] e_hold    = '0;
    logic [W-1:0] rq[$];
    logic [W-1:0] sq[$];
    int unsigned  held [W];

    always @(posedge clk) begin : upd
      logic [W-1:0] raw_v, used_v, nxt;
      logic         rst_v, all_diff;
      rst_v = (k == 0) ? rst_n0 : rst_n1;
      raw_v = (k == 0) ? btn0 : ~btn1;
      if (!rst_v) begin
        rq.delete();
        sq.delete();
        e_state   = '0;
        e_press   = '0;
        e_release = '0;
        e_hold    = '0;
        for (int unsigned c = 0; c < W; c++) held[c] = 0;
      end else begin
        used_v = (rq.size() >= 2) ? rq[0] : '0;
        rq.push_back(raw_v);
        if (rq.size() > 2) void'(rq.pop_front());
        sq.push_back(used_v);
        if (sq.size() > D) void'(sq.pop_front());
        nxt = e_state;
        e_hold = '0;
        for (int unsigned c = 0; c < W; c++) begin
          all_diff = (sq.size() == D);
          foreach (sq[j]) if (sq[j][c] == e_state[c]) all_diff = 1'b0;
          if (all_diff) nxt[c] = ~e_state[c];
          if (e_state[c]) held[c] = held[c] + 1;
          else            held[c] = 0;
`ifdef BTN_DEBOUNCE_HOLD_EN
          e_hold[c] = e_state[c] && (held[c] == H);
`endif
        end
        e_press   = nxt & ~e_state;
        e_release = ~nxt & e_state;
        e_state   = nxt;
      end
    end
  end

  logic [8*W-1:0] w_dut_all, w_ref_all;
  assign w_dut_all = {st0, pr0, rl0, ho0, st1, pr1, rl1, ho1};
  assign w_ref_all = {g_model[0].e_state, g_model[0].e_press, g_model[0].e_release, g_model[0].e_hold,
                      g_model[1].e_state, g_model[1].e_press, g_model[1].e_release, g_model[1].e_hold};

  task automatic test_reset();
    rst_n0 = 1'b0; rst_n1 = 1'b0; btn0 = 2'b11; btn1 = 2'b11;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      checks++;
      if (w_dut_all !== '0) begin
        errors++; $display("FAIL reset_zero: got %h want 0", w_dut_all);
      end
    end
    rst_n0 = 1'b1; rst_n1 = 1'b1;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      checks++;
      if (pr0 !== ((n == 6) ? 2'b11 : 2'b00)) begin
        errors++; $display("FAIL reset_exit_press edge %0d: got %b want %b", n, pr0, (n == 6) ? 2'b11 : 2'b00);
      end
      checks++;
      if (st0 !== ((n >= 6) ? 2'b11 : 2'b00)) begin
        errors++; $display("FAIL reset_exit_state edge %0d: got %b want %b", n, st0, (n >= 6) ? 2'b11 : 2'b00);
      end
      checks++;
      if (w_dut_all !== w_ref_all) begin
        errors++; $display("FAIL reset_model edge %0d: dut %h ref %h", n, w_dut_all, w_ref_all);
      end
    end
  endtask

  task automatic test_clean();
    btn0 = 2'b00;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      checks++;
      if (w_dut_all !== w_ref_all) begin
        errors++; $display("FAIL clean_settle edge %0d: dut %h ref %h", n, w_dut_all, w_ref_all);
      end
    end
    btn0 = 2'b01;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      checks++;
      if (pr0 !== ((n == 6) ? 2'b01 : 2'b00) || rl0 !== 2'b00) begin
        errors++; $display("FAIL clean_press edge %0d: press %b release %b", n, pr0, rl0);
      end
      checks++;
      if (st0 !== ((n >= 6) ? 2'b01 : 2'b00)) begin
        errors++; $display("FAIL clean_state edge %0d: got %b want %b", n, st0, (n >= 6) ? 2'b01 : 2'b00);
      end
      checks++;
      if (w_dut_all !== w_ref_all) begin
        errors++; $display("FAIL clean_model edge %0d: dut %h ref %h", n, w_dut_all, w_ref_all);
      end
    end
    btn0 = 2'b00;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      checks++;
      if (rl0 !== ((n == 6) ? 2'b01 : 2'b00) || pr0 !== 2'b00) begin
        errors++; $display("FAIL clean_release edge %0d: release %b press %b", n, rl0, pr0);
      end
      checks++;
      if (w_dut_all !== w_ref_all) begin
        errors++; $display("FAIL clean_rel_model edge %0d: dut %h ref %h", n, w_dut_all, w_ref_all);
      end
    end
  endtask

  task automatic test_bounce();
    logic [8:0] pat;
    pat = 9'b0_1110_1101;  // applied LSB first: 1,0,1,1,0,1,1,1,0
    for (int unsigned i = 0; i < 9; i++) begin
      btn0 = {1'b0, pat[i]};
      @(negedge clk);
      checks++;
      if (pr0 !== 2'b00 || st0 !== 2'b00) begin
        errors++; $display("FAIL bounce_glitch step %0d: press %b state %b", i, pr0, st0);
      end
    end
    btn0 = 2'b01;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      checks++;
      if (pr0 !== ((n == 6) ? 2'b01 : 2'b00)) begin
        errors++; $display("FAIL bounce_press edge %0d: got %b want %b", n, pr0, (n == 6) ? 2'b01 : 2'b00);
      end
      checks++;
      if (w_dut_all !== w_ref_all) begin
        errors++; $display("FAIL bounce_model edge %0d: dut %h ref %h", n, w_dut_all, w_ref_all);
      end
    end
    btn0 = 2'b00;
    repeat (12) @(negedge clk);
  endtask

  task automatic test_active_low();
    btn1 = 2'b00;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      checks++;
      if (pr1 !== ((n == 6) ? 2'b11 : 2'b00) || st1 !== ((n >= 6) ? 2'b11 : 2'b00)) begin
        errors++; $display("FAIL active_low edge %0d: press %b state %b", n, pr1, st1);
      end
      checks++;
      if (w_dut_all !== w_ref_all) begin
        errors++; $display("FAIL active_low_model edge %0d: dut %h ref %h", n, w_dut_all, w_ref_all);
      end
    end
    btn1 = 2'b11;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      checks++;
      if (rl1 !== ((n == 6) ? 2'b11 : 2'b00)) begin
        errors++; $display("FAIL active_low_release edge %0d: got %b", n, rl1);
      end
    end
  endtask

  task automatic test_reset_mid();
    btn0 = 2'b01;
    for (int n = 1; n <= 3; n++) begin
      @(negedge clk);
      checks++;
      if (pr0 !== 2'b00 || st0 !== 2'b00) begin
        errors++; $display("FAIL midreset_pre edge %0d: press %b state %b", n, pr0, st0);
      end
    end
    rst_n0 = 1'b0;
    @(negedge clk);
    checks++;
    if ({st0, pr0, rl0, ho0} !== '0) begin
      errors++; $display("FAIL midreset_clear: got %h want 0", {st0, pr0, rl0, ho0});
    end
    rst_n0 = 1'b1;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      checks++;
      if (pr0 !== ((n == 6) ? 2'b01 : 2'b00)) begin
        errors++; $display("FAIL midreset_press edge %0d: got %b want %b", n, pr0, (n == 6) ? 2'b01 : 2'b00);
      end
      checks++;
      if (w_dut_all !== w_ref_all) begin
        errors++; $display("FAIL midreset_model edge %0d: dut %h ref %h", n, w_dut_all, w_ref_all);
      end
    end
    btn0 = 2'b00;
    repeat (20) @(negedge clk);
  endtask

  task automatic test_hold();
    int press_n = -1;
    int hold_n  = -1;
    int hold_cnt = 0;
    btn0 = 2'b01;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      if (pr0[0]) press_n = n;
      if (ho0[0]) begin hold_cnt++; hold_n = n; end
      checks++;
      if (w_dut_all !== w_ref_all) begin
        errors++; $display("FAIL hold_model edge %0d: dut %h ref %h", n, w_dut_all, w_ref_all);
      end
    end
`ifdef BTN_DEBOUNCE_HOLD_EN
    checks++;
    if (hold_cnt != 1 || hold_n - press_n != int'(H)) begin
      errors++; $display("FAIL hold_pulse: count %0d offset %0d want count 1 offset %0d", hold_cnt, hold_n - press_n, H);
    end
`else
    checks++;
    if (hold_cnt != 0) begin
      errors++; $display("FAIL hold_disabled: count %0d at %0d want 0", hold_cnt, hold_n);
    end
`endif
    btn0 = 2'b00;
    repeat (12) @(negedge clk);
  endtask

  task automatic test_random();
    bit calm = 1'b0;
    for (int unsigned cyc = 0; cyc < 1500; cyc++) begin
      if (cyc % 40 == 0) calm = 1'($urandom_range(0, 1));
      for (int unsigned b = 0; b < W; b++) begin
        if ($urandom_range(0, calm ? 24 : 2) == 0) btn0[b] = ~btn0[b];
        if ($urandom_range(0, calm ? 24 : 2) == 0) btn1[b] = ~btn1[b];
      end
      rst_n0 = ($urandom_range(0, 299) != 0);
      rst_n1 = ($urandom_range(0, 299) != 0);
      @(negedge clk);
      checks++;
      if (w_dut_all !== w_ref_all) begin
        errors++; $display("FAIL random cycle %0d: dut %h ref %h", cyc, w_dut_all, w_ref_all);
      end
    end
    rst_n0 = 1'b1;
    rst_n1 = 1'b1;
  endtask

  initial begin
    test_reset();
    test_clean();
    test_bounce();
    test_active_low();
    test_reset_mid();
    test_hold();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
